// File: rtl/debounce_pkg.sv
// Shared definitions for the button debouncer: FSM state encoding and default timing constants.
package debounce_pkg;

    localparam int unsigned STABLE_CYCLES_DEFAULT = 500000;
    localparam int unsigned SYNC_STAGES_DEFAULT   = 2;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b11,
        WAIT_LOW    = 2'b10
    } db_state_e;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
module synchronizer #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/debouncer.sv
// Debouncer: synchronizes a raw button level, qualifies it over a stable window,
// and produces a clean registered level plus one-cycle rise/fall strobes.
module debouncer #(
    parameter int unsigned STABLE_CYCLES = debounce_pkg::STABLE_CYCLES_DEFAULT,
    parameter int unsigned SYNC_STAGES   = debounce_pkg::SYNC_STAGES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic signal,
    output logic signal_debounced,
    output logic rise,
    output logic fall
);

    import debounce_pkg::*;

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

    logic             sync_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    synchronizer #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (signal),
        .q    (sync_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // Any reversal during a WAIT state drops back and restarts qualification from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE_LOW: begin
                if (sync_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HIGH: begin
                if (!sync_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    assign signal_debounced = level_q;
    assign rise             = rise_q;
    assign fall             = fall_q;

endmodule

// File: tb/tb_debouncer.sv
// Self-checking bench for debouncer with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_debouncer;

    localparam int unsigned SC = 4;
    localparam int unsigned SS = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sig   = 1'b0;
    logic deb, rise, fall;

    always #5 clk = ~clk;

    debouncer #(
        .STABLE_CYCLES(SC),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .signal          (sig),
        .signal_debounced(deb),
        .rise            (rise),
        .fall            (fall)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference: the output flips once the synchronized input has disagreed with it
    // on SC+1 consecutive edges; the synchronizer is a plain SS-cycle delay.
    logic pipe[$];
    logic m_out, m_rise, m_fall;
    int   run;

    function automatic void model_reset();
        pipe.delete();
        for (int i = 0; i < int'(SS); i++) pipe.push_back(1'b0);
        m_out  = 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        run    = 0;
    endfunction

    function automatic void model_step(input logic s);
        logic seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        seen = pipe[$];
        void'(pipe.pop_back());
        pipe.push_front(s);
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (seen != m_out) run++;
        else run = 0;
        if (run == int'(SC) + 1) begin
            m_out  = ~m_out;
            m_rise = m_out;
            m_fall = ~m_out;
            run    = 0;
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %b expected %b", tag, $time, obs, expv);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s at %0t: observed %0d expected %0d", tag, $time, obs, expv);
        end
    endtask

    task automatic tick(input logic s);
        sig = s;
        @(posedge clk);
        model_step(s);
        #1;
        check("level", deb, m_out);
        check("rise", rise, m_rise);
        check("fall", fall, m_fall);
    endtask

    initial begin
        int lat, nr, nf, hc, rise_t, fall_t, left, len;
        logic v;

        model_reset();
        repeat (3) tick(1'b0);
        rst_n = 1'b1;

        // Idle low after reset
        nr = 0; nf = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            nr += int'(rise); nf += int'(fall);
        end
        check_int("idle_strobes", nr + nf, 0);

        // Clean step
        lat = -1; nf = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1'b1);
            if (rise && lat < 0) lat = i;
            nf += int'(fall);
        end
        check_int("step_latency", lat, int'(SS + SC));
        check_int("step_no_fall", nf, 0);
        repeat (12) tick(1'b0);

        // Bounce then hold high
        nr = 0;
        for (int p = 0; p < 4; p++) begin
            repeat (2) tick((p % 2) == 0);
            nr += int'(rise);
        end
        check_int("bounce_no_rise", nr, 0);
        lat = -1;
        for (int i = 0; i < 14; i++) begin
            tick(1'b1);
            if (rise && lat < 0) lat = i;
        end
        check_int("bounce_latency", lat, int'(SS + SC));
        repeat (12) tick(1'b0);

        // Short glitch
        nr = 0;
        for (int i = 0; i < 15; i++) begin
            tick(i < 3);
            nr += int'(rise) + int'(fall) + int'(deb);
        end
        check_int("glitch_quiet", nr, 0);

        // Press then release
        nr = 0; nf = 0; hc = 0; rise_t = -1; fall_t = -1;
        for (int i = 0; i < 30; i++) begin
            tick(i < 10);
            if (rise) begin nr++; rise_t = i; end
            if (fall) begin nf++; fall_t = i; end
            hc += int'(deb);
        end
        check_int("press_rises", nr, 1);
        check_int("press_falls", nf, 1);
        check_int("press_gap", fall_t - rise_t, 10);
        check_int("press_high_cycles", hc, 10);

        // Async reset while output is high
        repeat (8) tick(1'b1);
        check("pre_reset_high", deb, 1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_high_level", deb, 1'b0);
        check("rst_high_rise", rise, 1'b0);
        check("rst_high_fall", fall, 1'b0);
        repeat (2) tick(1'b0);
        rst_n = 1'b1;
        repeat (5) tick(1'b0);

        // Reset two cycles into WAIT_HIGH, then release with input still high
        repeat (4) tick(1'b1);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_wait_level", deb, 1'b0);
        check("rst_wait_rise", rise, 1'b0);
        repeat (2) tick(1'b1);
        rst_n = 1'b1;
        lat = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            if (rise && lat < 0) lat = i;
        end
        check_int("rst_release_latency", lat, int'(SS + SC));

        // Random bursts of varying length
        left = 600;
        v = 1'b1;
        while (left > 0) begin
            v   = ~v;
            len = int'($urandom_range(1, 9));
            for (int i = 0; i < len; i++) tick(v);
            left -= len;
        end
        repeat (12) tick(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
